vga_frame_arbiter: RTL
======================

Name: vga_frame_arbiter

Overview:
Shares the single-port pixel frame RAM (3-bit pixels, 640x240, registered read address) between three requesters: the VGA scan-out reader, a pixel writer (drawing engine), and a built-in full-frame clear engine. Scan-out reads always win, so the display never tears. Writes and clears use the RAM only in cycles the scanner leaves free. Sits between the timing generator / drawing logic and the frame RAM instance.

Parameters:
DATA_WIDTH, 3, pixel width in bits
ADDR_WIDTH, 19, frame RAM address width
N_PIXELS, 153600, number of valid pixel locations (640*240)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
scan_req  in  1  scanner read request this cycle
scan_addr  in  ADDR_WIDTH  scanner read address
scan_data  out  DATA_WIDTH  pixel returned for a scan request
scan_valid  out  1  scan_data valid this cycle
wr_valid  in  1  writer has a pixel to write
wr_addr  in  ADDR_WIDTH  writer address
wr_data  in  DATA_WIDTH  writer pixel
wr_ready  out  1  writer transfer accepted this cycle
clear_start  in  1  start full-frame clear (single-cycle pulse)
clear_color  in  DATA_WIDTH  fill value, sampled on accepted clear_start
busy  out  1  clear in progress
clear_done  out  1  one-cycle pulse after the last clear write
wr_oob  out  1  sticky: an accepted write had wr_addr >= N_PIXELS
ram_addr  out  ADDR_WIDTH  to frame RAM addr
ram_data  out  DATA_WIDTH  to frame RAM data
ram_we  out  1  to frame RAM we
ram_q  in  DATA_WIDTH  from frame RAM q

Behaviour:
- Reset (async assert, sync use after deassert) forces:
  - scan_data=0, scan_valid=0, busy=0, clear_done=0, wr_oob=0.
  - FSM=IDLE, clear counter=0, latched colour=0.
  - The scan pipeline is flushed.
- RAM-side outputs are combinational from the current-cycle grant.
- Priority per cycle, highest first:
  - scan_req: ram_addr=scan_addr, ram_we=0.
  - FSM=CLEAR: ram_addr=clear counter, ram_data=latched colour, ram_we=1.
  - wr_valid with wr_ready: ram_addr=wr_addr, ram_data=wr_data, ram_we=1 only if wr_addr<N_PIXELS.
  - Otherwise: ram_we=0, ram_addr holds scan_addr.
- Read latency:
  - scan_req in cycle t gives scan_valid=1 in cycle t+2, with scan_data = RAM content at scan_addr.
  - Stage 1 is a registered request flag. Stage 2 registers ram_q into scan_data together with scan_valid.
  - Back-to-back requests are fully pipelined, one pixel per cycle.
  - scan_data holds its value when scan_valid=0.
- Write handshake:
  - wr_ready = !scan_req && FSM==IDLE (combinational). Transfer occurs when wr_valid && wr_ready.
  - The writer must hold addr/data stable until it sees ready.
  - A write to a location read in the same cycle cannot happen (scan wins).
  - Out-of-range write: accepted (wr_ready=1), not written, sets wr_oob. wr_oob is cleared only by reset.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_start. Latch clear_color, counter=0, busy=1 from the next cycle.
  - A cycle where clear_start arrives with no scan_req may also carry a normal write. The clear starts the following cycle.
  - In CLEAR, each cycle without scan_req writes one pixel and increments the counter.
  - Cycles with scan_req stall the counter, with no write.
  - On writing address N_PIXELS-1: go to IDLE, busy=0, clear_done=1 for exactly the next cycle. The counter returns to 0.
  - clear_start while in CLEAR is ignored: no restart, colour unchanged.
  - Reset during CLEAR: aborts immediately. Partial contents remain; no clear_done.
- Counter width is ADDR_WIDTH. It never exceeds N_PIXELS-1.
- Minimum clear duration with no scan traffic: N_PIXELS cycles.

Test Plan:
- Reset, then idle: all outputs 0, ram_we=0; wr_ready=1 when scan_req=0.
- Write 5 to addr 100 with scan_req=0, then scan_req at addr 100 in cycle t -> scan_valid=1 and scan_data=5 in cycle t+2. Scan 100,101,102 back-to-back -> three consecutive valid cycles in order.
- wr_valid held with scan_req high for 3 cycles -> wr_ready=0, ram_we=0 for those 3 cycles; write accepted on the first cycle scan_req=0.
- clear_start with colour 3 and no scan traffic -> busy high for 153600 cycles, then clear_done pulses once. Reads of addr 0 and 153599 return 3; wr_ready=0 throughout.
- Clear with scan_req asserted every other cycle -> clear takes 307200 cycles. Scan data is unaffected by clear writes in progress, and the scan pipeline keeps full throughput.
- Write to addr 153600 -> wr_ready=1, ram_we=0, wr_oob=1 and sticky. Separately, reset_n low mid-clear -> busy=0 immediately, no clear_done pulse.

Source files
------------

// File: rtl/vga_frame_arbiter.sv
// vga_frame_arbiter: shares one single-port frame RAM between scan-out reads,
// a pixel writer and a full-frame clear engine. Scan-out reads always win.
module vga_frame_arbiter #(
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 19,
  parameter int N_PIXELS   = 153600
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  scan_req,
  input  logic [ADDR_WIDTH-1:0] scan_addr,
  output logic [DATA_WIDTH-1:0] scan_data,
  output logic                  scan_valid,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  clear_start,
  input  logic [DATA_WIDTH-1:0] clear_color,
  output logic                  busy,
  output logic                  clear_done,
  output logic                  wr_oob,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_PIXELS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [DATA_WIDTH-1:0] r_clr_color;
  logic                  r_clear_done;
  logic                  r_wr_oob;
  logic                  r_scan_p1;
  logic [DATA_WIDTH-1:0] r_scan_data;
  logic                  r_scan_valid;

  logic w_wr_xfer;
  logic w_wr_in_range;
  logic w_clr_write;
  logic w_clr_last;

  // Writer handshake: a transfer happens in every cycle where wr_valid and
  // wr_ready are both high. wr_ready is combinational and drops whenever a
  // scan read or the clear engine owns the RAM; while wr_valid is high and
  // wr_ready is low the writer keeps wr_addr/wr_data stable.
  assign w_wr_in_range = (wr_addr <= LAST_ADDR);
  assign w_wr_xfer     = wr_valid && wr_ready;
  assign w_clr_write   = (r_state == ST_CLEAR) && !scan_req;
  assign w_clr_last    = w_clr_write && (r_clr_cnt == LAST_ADDR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (clear_start) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (w_clr_last)  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // RAM port mux: scan read, then clear write, then writer; an idle port
  // keeps presenting the scan address.
  always_comb begin
    busy     = 1'b0;
    wr_ready = 1'b0;
    ram_addr = scan_addr;
    ram_data = wr_data;
    ram_we   = 1'b0;
    case (r_state)
      ST_IDLE:  wr_ready = !scan_req;
      ST_CLEAR: busy     = 1'b1;
      default:  busy     = 1'b0;
    endcase
    if (scan_req) begin
      ram_addr = scan_addr;
      ram_we   = 1'b0;
    end else if (r_state == ST_CLEAR) begin
      ram_addr = r_clr_cnt;
      ram_data = r_clr_color;
      ram_we   = 1'b1;
    end else if (wr_valid) begin
      ram_addr = wr_addr;
      ram_data = wr_data;
      ram_we   = w_wr_in_range;
    end
  end

  // Clear address counter and fill colour; the colour is only captured when
  // a clear is actually accepted, so a clear_start during CLEAR is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clr_cnt   <= '0;
      r_clr_color <= '0;
    end else if (r_state == ST_IDLE) begin
      r_clr_cnt <= '0;
      if (clear_start) r_clr_color <= clear_color;
    end else if (w_clr_write) begin
      r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clear_done <= 1'b0;
      r_wr_oob     <= 1'b0;
    end else begin
      r_clear_done <= w_clr_last;
      r_wr_oob     <= r_wr_oob | (w_wr_xfer && !w_wr_in_range);
    end
  end

  // Two-stage read return: the RAM registers the address on the request
  // edge, so ram_q is valid one cycle later and is captured on the next edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scan_p1    <= 1'b0;
      r_scan_valid <= 1'b0;
      r_scan_data  <= '0;
    end else begin
      r_scan_p1    <= scan_req;
      r_scan_valid <= r_scan_p1;
      if (r_scan_p1) r_scan_data <= ram_q;
    end
  end

  assign scan_data  = r_scan_data;
  assign scan_valid = r_scan_valid;
  assign clear_done = r_clear_done;
  assign wr_oob     = r_wr_oob;
  assign dbg_state  = (r_state == ST_CLEAR);

endmodule
